ram_stream_reader: RTL and testbench

//   Burst reader for one port of the synchronous dual-port RAM (1-cycle registered read).
//   On start, reads LENGTH consecutive words from BASE_ADDR (wrapping at WORDS).

---
 rtl/ram_stream_reader.sv | 149 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Burst reader: streams LENGTH words from a 1-cycle registered-read RAM port
// onto a valid/ready stream, with a 2-entry output FIFO and credit-gated reads.
module ram_stream_reader #(
    parameter int DW    = 8,
    parameter int WORDS = 256,
    localparam int AW   = $clog2(WORDS),
    localparam int LW   = $clog2(WORDS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_qout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic          r_rd;
    logic          r_qv;
    logic [LW-1:0] r_remain;
    logic [LW-1:0] r_beats;
    logic [DW-1:0] r_fifo [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    logic          w_pop;
    logic          w_cap;
    logic          w_qv_nxt;
    logic          w_issue;
    logic [1:0]    w_cnt_nxt;
    logic [AW-1:0] w_addr_inc;

    // RAM data on the bus is captured when the FIFO has room (or frees a slot
    // this cycle). Uncaptured data stays valid because the address is held,
    // so the RAM output register acts as a third holding slot.
    assign w_pop      = m_valid & m_ready;
    assign w_cap      = r_qv & ((r_count != 2'd2) | w_pop);
    assign w_cnt_nxt  = r_count + 2'(w_cap) - 2'(w_pop);
    assign w_qv_nxt   = r_rd | (r_qv & ~w_cap);
    // A new read moves the address, so it is only issued when the word that
    // will be on the bus next cycle is certain to fit into the FIFO.
    assign w_issue    = (r_state == S_RUN) & (r_remain != '0)
                      & (~w_qv_nxt | (w_cnt_nxt != 2'd2));
    assign w_addr_inc = (r_addr == AW'(WORDS - 1)) ? '0 : r_addr + 1'b1;

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign mem_addr = r_addr;
    assign mem_rd   = r_rd;
    assign mem_wr   = 1'b0;
    assign mem_din  = '0;
    assign m_valid  = (r_count != 2'd0);
    assign m_data   = r_fifo[r_rptr];
    assign m_last   = m_valid & (r_beats == LW'(1));

    // Burst control FSM: read issue, address walk and beat accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_remain <= '0;
            r_beats  <= '0;
        end else begin
            r_rd <= 1'b0;
            if (w_pop) begin
                r_beats <= r_beats - 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_beats <= length;
                        if (length == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state  <= S_RUN;
                            r_rd     <= 1'b1;
                            r_remain <= length - 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_rd     <= 1'b1;
                        r_addr   <= w_addr_inc;
                        r_remain <= r_remain - 1'b1;
                    end
                    if (r_remain == '0) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_beats == LW'(1))) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-data capture and 2-entry output FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qv      <= 1'b0;
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
        end else begin
            r_qv    <= w_qv_nxt;
            r_count <= w_cnt_nxt;
            if (w_cap) begin
                r_fifo[r_wptr] <= mem_qout;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: registered-read RAM model, expected-beat
// scoreboard queue, one task per scenario.
module tb_ram_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_din;
    logic [7:0] mem_qout;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    logic [7:0] ram [256];

    logic [8:0] exp_q [$];
    logic [8:0] obs_q [$];
    logic [7:0] adr_q [$];
    int         beat_cyc [$];

    int errors = 0;
    int checks = 0;
    int stall_err, over_err, busy_err;
    int done_cnt, done_cyc, first_v, first_rd, timed_out;

    ram_stream_reader #(.DW(8), .WORDS(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_din   (mem_din),
        .mem_qout  (mem_qout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // RAM model: registered read of the current address every cycle
    always @(posedge clk) mem_qout <= ram[mem_addr];

    // Monitor only: starts a burst and records beats, addresses and timing.
    // mode 0: ready=1; mode 1: random ready; mode 2: ready=1, start held while busy
    task automatic run_burst(input logic [7:0] b, input logic [8:0] n,
                             input int mode, input int budget);
        int         issued;
        int         popped;
        logic       stalled;
        logic [8:0] prev;
        obs_q.delete();
        adr_q.delete();
        beat_cyc.delete();
        stall_err = 0; over_err = 0; busy_err = 0;
        done_cnt = 0; done_cyc = -1; first_v = -1; first_rd = -1;
        timed_out = 1;
        issued = 0; popped = 0; stalled = 1'b0; prev = '0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = n;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            m_ready = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (mode == 2) begin
                start     = (c >= 1 && c <= 3);
                base_addr = 8'd100;
                length    = 9'd9;
            end
            @(negedge clk);
            if (mem_rd) begin
                adr_q.push_back(mem_addr);
                issued++;
                if (first_rd < 0) first_rd = c;
            end
            if (issued - popped > 3) over_err++;
            if (stalled && (!m_valid || {m_last, m_data} !== prev)) stall_err++;
            if (m_valid && first_v < 0) first_v = c;
            if (m_valid && m_ready) begin
                obs_q.push_back({m_last, m_data});
                beat_cyc.push_back(c);
                popped++;
            end
            stalled = m_valid && !m_ready;
            prev = {m_last, m_data};
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy !== (done_cyc < 0 || c == done_cyc)) busy_err++;
            if (done_cyc >= 0 && c >= done_cyc + 3) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd, m_valid, m_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {busy, done, mem_rd, m_valid, m_last});
        end
        checks++;
        if ({mem_addr, m_data} !== 16'h0) begin
            errors++;
            $display("FAIL reset_addr_data got %h want 0000", {mem_addr, m_data});
        end
        checks++;
        if ({mem_wr, mem_din} !== 9'h0) begin
            errors++;
            $display("FAIL reset_wr_din got %h want 000", {mem_wr, mem_din});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [8:0] e, o;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), ram[8'(i)]});
        run_burst(8'd0, 9'd4, 0, 40);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL basic_timeout got no done want done");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic_beat got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL basic_extra got %0d extra want 0", obs_q.size());
        end
        checks++;
        if (first_rd != 0 || adr_q.size() == 0 || adr_q[0] !== 8'd0) begin
            errors++;
            $display("FAIL basic_first_read got cycle %0d want cycle 0 addr 0", first_rd);
        end
        checks++;
        if (first_v != 2) begin
            errors++;
            $display("FAIL basic_latency got %0d want 2", first_v);
        end
        checks++;
        if (beat_cyc.size() != 4 || beat_cyc[3] - beat_cyc[0] != 3) begin
            errors++;
            $display("FAIL basic_throughput got %0d beats not back-to-back want 4 consecutive",
                     beat_cyc.size());
        end
        checks++;
        if (beat_cyc.size() != 4 || done_cyc != beat_cyc[3] + 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done got cycle %0d count %0d want 1 pulse after last beat",
                     done_cyc, done_cnt);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL basic_busy got %0d bad cycles want 0", busy_err);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] e, o;
        logic [7:0] want [4];
        want[0] = 8'd254; want[1] = 8'd255; want[2] = 8'd0; want[3] = 8'd1;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), ram[want[i]]});
        run_burst(8'd254, 9'd4, 0, 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap_beat got %h want %h", o, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (adr_q.size() != 4 || adr_q[i] !== want[i]) begin
                errors++;
                $display("FAIL wrap_addr idx %0d got %0d reads want addr %0d",
                         i, adr_q.size(), want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] e, o;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), ram[8'(10 + r + i)]});
            run_burst(8'(10 + r), 9'd8, 1, 300);
            checks++;
            if (timed_out != 0) begin
                errors++;
                $display("FAIL bp_timeout round %0d got no done want done", r);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL bp_beat got %h want %h", o, e);
                end
            end
            checks++;
            if (obs_q.size() != 0) begin
                errors++;
                $display("FAIL bp_extra got %0d extra want 0", obs_q.size());
            end
            checks++;
            if (stall_err != 0) begin
                errors++;
                $display("FAIL bp_stable got %0d changes while stalled want 0", stall_err);
            end
            checks++;
            if (over_err != 0) begin
                errors++;
                $display("FAIL bp_overread got %0d cycles over 3 outstanding want 0", over_err);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [8:0] e, o;
        run_burst(8'd5, 9'd0, 0, 20);
        checks++;
        if (done_cyc != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_done got cycle %0d count %0d want cycle 0 count 1",
                     done_cyc, done_cnt);
        end
        checks++;
        if (first_v != -1 || adr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_quiet got valid at %0d reads %0d want none", first_v, adr_q.size());
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), ram[8'(50 + i)]});
        run_burst(8'd50, 9'd4, 2, 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy_start_beat got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0 || done_cnt != 1 || busy_err != 0) begin
            errors++;
            $display("FAIL busy_start_extra got extra %0d done %0d busyerr %0d want 0 1 0",
                     obs_q.size(), done_cnt, busy_err);
        end
    endtask

    task automatic test_full();
        logic [8:0] e, o;
        int         bad;
        int         lasts;
        for (int i = 0; i < 256; i++) exp_q.push_back({(i == 255), ram[8'(17 + i)]});
        run_burst(8'd17, 9'd256, 0, 400);
        lasts = 0;
        foreach (obs_q[i]) if (obs_q[i][8]) lasts++;
        checks++;
        if (lasts != 1) begin
            errors++;
            $display("FAIL full_last_count got %0d want 1", lasts);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL full_beat got %h want %h", o, e);
            end
        end
        bad = 0;
        foreach (adr_q[i]) if (adr_q[i] !== 8'(17 + i)) bad++;
        checks++;
        if (adr_q.size() != 256 || bad != 0) begin
            errors++;
            $display("FAIL full_addr got %0d reads %0d wrong want 256 reads 0 wrong",
                     adr_q.size(), bad);
        end
        checks++;
        if (beat_cyc.size() != 256 || beat_cyc[255] - beat_cyc[0] != 255) begin
            errors++;
            $display("FAIL full_throughput got %0d beats want 256 consecutive", beat_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e, o;
        int         found;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        found = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'd0; length = 9'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_valid && m_data == 8'd3) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL rstmid_beat3 got no beat 3 want beat 3");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_rd, m_valid, m_last, mem_addr, m_data} !== 21'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h want 000000",
                     {busy, done, mem_rd, m_valid, m_last, mem_addr, m_data});
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), ram[8'(40 + i)]});
        run_burst(8'd40, 9'd8, 0, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_beat got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL rstmid_clean got extra %0d done %0d want 0 1", obs_q.size(), done_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        m_ready = 1'b1;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
